pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline register stage that generalises the fixed per-stage register bars (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. It carries an opaque WIDTH-bit payload with valid/ready handshaking, flush-to-bubble, and an optional skid entry, so upstream ready never depends combinationally on downstream ready. One instance sits between each pair of pipeline stages. Stage-specific fields are packed into the payload by the surrounding datapath.

## Interface
- WIDTH, 32: payload width in bits; legal range is 1 or more.
- BUBBLE, '0: value (WIDTH bits) driven on out_data whenever out_valid is low.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset; synchronous, active-low.
- flush  in  1  kill every held entry at the next edge.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage presents out_data.
- out_ready  in  1  downstream accepts this cycle (the hit/enable term).
- out_data  out  WIDTH  head payload, or BUBBLE.
- occupancy  out  2  number of held entries (0–2).

## Operation
- Transfer rules:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - Both may occur in the same cycle.
- States:
  - EMPTY: no entries.
  - FULL: main slot holds the head.
  - SKID: main slot plus skid slot. SKID exists only when the macro is on.
- EMPTY transitions:
  - Accept moves to FULL; main receives in_data.
- FULL transitions:
  - Emit without accept moves to EMPTY.
  - Accept and emit together stay in FULL; main is overwritten with in_data.
  - Accept without emit moves to SKID; skid receives in_data. Macro on only.
  - Neither stays in FULL.
- SKID transitions:
  - Emit moves to FULL; main takes skid.
  - No accept is possible in SKID, because in_ready is low.
- Ordering is strict FIFO; payloads are never reordered or duplicated.
- Flush has highest priority below reset:
  - Next state is EMPTY and both slots are invalidated.
  - An accept in the flush cycle is discarded.
  - An emit in the flush cycle still counts; the downstream consumer sees it.
- Reset: nRST low at an edge forces EMPTY and clears both slots to BUBBLE, regardless of flush or any handshake, including mid-transfer.
- out_data:
  - Main slot contents when out_valid is high.
  - BUBBLE otherwise. Slot contents never leak when invalid.
- occupancy values: EMPTY=0, FULL=1, SKID=2.

## Timing
- Latency: an accept at edge N gives out_valid high in cycle N+1. There is no combinational in-to-out path.
- Throughput: one transfer per cycle when out_ready is held high.
- Reset values:
  - out_valid = 0
  - out_data = BUBBLE
  - occupancy = 0
  - in_ready = 1 the cycle after reset deasserts; 0 while nRST is low.
- in_ready with the macro on: registered; high unless the state is SKID.
- in_ready with the macro off: in_ready = ~out_valid | out_ready, combinational from out_ready.
- flush does not gate in_ready combinationally. Data accepted in a flush cycle is dropped.
- A flush and a reset in the same cycle give the reset result.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Two-entry elastic stage with a registered in_ready.
  - SKID state present; occupancy reaches 2.
- PIPE_STAGE_SKID_EN undefined:
  - Single-entry stage; SKID state and skid slot are removed.
  - in_ready is combinational as stated in Timing; occupancy never exceeds 1.
  - All other behaviour is identical.

## Structure
- Add pipe_state_t (EMPTY, FULL, SKID; 2-bit enum) to cpu_types_pkg.
- Add PIPE_OCC_W = 2 to cpu_types_pkg.
- Payload structs for each stage boundary belong in cpu_types_pkg; this block treats them as flat WIDTH-bit vectors.
- Sub-module pipe_slot: one WIDTH-bit register with load enable, synchronous clear to BUBBLE, and a valid bit. Instantiate it once for main and, under the macro, once for skid.
- One state register plus next-state logic in pipe_stage_reg.

## Test plan
- Reset and basic transfer:
  - Stimulus: hold nRST low for 2 cycles with in_valid=1 and in_data=32'hDEADBEEF.
  - Required: out_valid=0, out_data=0, occupancy=0.
  - Then release reset and accept once with out_ready=1: out_data=32'hDEADBEEF one cycle later, then EMPTY.
- Streaming:
  - Stimulus: in_valid=1 for 8 cycles with data 1..8, out_ready=1 throughout.
  - Required: outputs 1..8 on consecutive cycles, each one cycle late, with no gaps.
- Backpressure (macro on):
  - Stimulus: with out_ready=0, send 1, 2, 3.
  - Required: occupancy reaches 2 and in_ready drops, so 3 is held upstream.
  - Then raise out_ready: output order is 1, 2, 3 with no loss.
- Backpressure (macro off):
  - Stimulus: same as above.
  - Required: occupancy peaks at 1, in_ready=0 while out_ready=0, and output order is 1, 2, 3.
- Flush:
  - Stimulus: in SKID holding 5 and 6, assert flush with in_valid=1 and in_data=7.
  - Required: next cycle out_valid=0, out_data=BUBBLE, occupancy=0; 7 is never emitted.
- Reset mid-operation with flush:
  - Stimulus: in FULL holding 9, assert nRST low and flush together.
  - Required: EMPTY, out_data=BUBBLE; the next accepted 10 appears one cycle after its accept.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage-register occupancy state and its width.
// pipe_occ maps a stage state to its held-entry count.
package cpu_types_pkg;

  localparam int PIPE_OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  function automatic logic [PIPE_OCC_W-1:0] pipe_occ(input pipe_state_t s);
    case (s)
      FULL:    return 2'd1;
      SKID:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle around one pipeline stage register: upstream in_*, downstream out_*, flush, occupancy.
// master drives payload/ready from the surrounding stages; slave is the stage register itself.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);

  logic                              flush;
  logic                              in_valid;
  logic                              in_ready;
  logic [WIDTH-1:0]                  in_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [WIDTH-1:0]                  out_data;
  logic [cpu_types_pkg::PIPE_OCC_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One payload register with load enable, synchronous clear to BUBBLE and a valid bit.
// Latency 1 cycle; clear wins over load, reset wins over both.
module pipe_slot #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  logic [WIDTH-1:0] dat_q, dat_d;
  logic             vld_q, vld_d;

  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (clr) begin
      dat_d = BUBBLE;
      vld_d = 1'b0;
    end else if (ld) begin
      dat_d = d;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      dat_q <= BUBBLE;
      vld_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign q   = dat_q;
  assign vld = vld_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register, 1-cycle in->out latency, flush-to-bubble. PIPE_STAGE_SKID_EN adds a skid
// entry so in_ready is registered; without it in_ready = ~out_valid | out_ready (single entry).
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  pipe_stage_reg_if.slave  bus
);

  pipe_state_t      state_q, state_d;
  logic             accept, emit;
  logic             main_ld, main_clr, main_vld;
  logic [WIDTH-1:0] main_din, main_q;
  logic             in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_ld, skid_clr, skid_vld;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q, in_ready_d;
`else
  logic             rst_done_q, rst_done_d;
`endif

  assign accept = bus.in_valid & in_ready;
  assign emit   = main_vld & bus.out_ready;

  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    main_din = bus.in_data;
`ifdef PIPE_STAGE_SKID_EN
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
`endif
    if (bus.flush) begin
      // An emit this cycle has already been seen downstream; only held entries die.
      state_d  = EMPTY;
      main_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clr = 1'b1;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            main_ld = 1'b1;
          end
        end
        FULL: begin
          case ({accept, emit})
            2'b01: begin
              state_d  = EMPTY;
              main_clr = 1'b1;
            end
            2'b11:   main_ld = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            2'b10: begin
              state_d = SKID;
              skid_ld = 1'b1;
            end
`endif
            default: ;
          endcase
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (emit) begin
            state_d  = skid_vld ? FULL : EMPTY;
            main_ld  = 1'b1;
            main_din = skid_q;
            skid_clr = 1'b1;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_main (
    .CLK  (CLK),
    .nRST (nRST),
    .ld   (main_ld),
    .clr  (main_clr),
    .d    (main_din),
    .q    (main_q),
    .vld  (main_vld)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_skid (
    .CLK  (CLK),
    .nRST (nRST),
    .ld   (skid_ld),
    .clr  (skid_clr),
    .d    (bus.in_data),
    .q    (skid_q),
    .vld  (skid_vld)
  );

  assign in_ready_d = (state_d != SKID);

  always_ff @(posedge CLK) begin
    if (!nRST) in_ready_q <= 1'b0;
    else       in_ready_q <= in_ready_d;
  end

  assign in_ready = in_ready_q;
`else
  assign rst_done_d = 1'b1;

  always_ff @(posedge CLK) begin
    if (!nRST) rst_done_q <= 1'b0;
    else       rst_done_q <= rst_done_d;
  end

  assign in_ready = rst_done_q & (~main_vld | bus.out_ready);
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_vld;
  assign bus.out_data  = main_vld ? main_q : BUBBLE;
  assign bus.occupancy = pipe_occ(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, backpressure, flush, reset-with-flush.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam int EXP_PEAK = 2;
`else
  localparam int EXP_PEAK = 1;
`endif

  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_err;
  logic [31:0] got_q[$];

  pipe_stage_reg_if #(.WIDTH(32)) ifc ();

  pipe_stage_reg #(.WIDTH(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (ifc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (ifc.out_valid && ifc.out_ready) got_q.push_back(ifc.out_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int peak;
    logic saw_block;
    n_checks = 0;
    n_err    = 0;

    // reset with a live upstream offer
    nRST          = 1'b0;
    ifc.flush     = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 32'hDEADBEEF;
    ifc.out_ready = 1'b0;
    cyc();
    cyc();
    @(negedge CLK);
    chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("rst_out_data",  ifc.out_data, 32'd0);
    chk("rst_occ",       {30'd0, ifc.occupancy}, 32'd0);
    chk("rst_in_ready",  {31'd0, ifc.in_ready}, 32'd0);
    cyc();
    nRST         = 1'b1;
    ifc.in_valid = 1'b0;
    cyc();
    @(negedge CLK);
    chk("post_rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    cyc();
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 32'hDEADBEEF;
    ifc.out_ready = 1'b1;
    cyc();
    ifc.in_valid = 1'b0;
    @(negedge CLK);
    chk("basic_out_valid", {31'd0, ifc.out_valid}, 32'd1);
    chk("basic_out_data",  ifc.out_data, 32'hDEADBEEF);
    chk("basic_occ",       {30'd0, ifc.occupancy}, 32'd1);
    cyc();
    @(negedge CLK);
    chk("basic_empty_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("basic_empty_occ",   {30'd0, ifc.occupancy}, 32'd0);
    chk("basic_q_size", got_q.size(), 32'd1);
    got_q.delete();

    // streaming 1..8
    cyc();
    for (int i = 1; i <= 8; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = i;
      @(negedge CLK);
      chk("stream_in_ready", {31'd0, ifc.in_ready}, 32'd1);
      if (i > 1) chk("stream_out_data", ifc.out_data, i - 1);
      else       chk("stream_first_valid", {31'd0, ifc.out_valid}, 32'd0);
      cyc();
    end
    ifc.in_valid = 1'b0;
    @(negedge CLK);
    chk("stream_last", ifc.out_data, 32'd8);
    cyc();
    @(negedge CLK);
    chk("stream_drained", {31'd0, ifc.out_valid}, 32'd0);
    chk("stream_q_size", got_q.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) chk("stream_order", got_q[i], i + 1);
    got_q.delete();

    // backpressure: send 1,2,3 with out_ready low for 5 cycles
    cyc();
    idx = 0;
    peak = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 12; c++) begin
      ifc.out_ready = (c >= 5);
      ifc.in_valid  = (idx < 3);
      ifc.in_data   = idx + 1;
      @(negedge CLK);
      if (int'(ifc.occupancy) > peak) peak = int'(ifc.occupancy);
      if (!ifc.out_ready && ifc.in_valid && !ifc.in_ready) saw_block = 1'b1;
      if (c == 4) begin
        chk("bp_occ_held", {30'd0, ifc.occupancy}, EXP_PEAK);
        chk("bp_in_ready_low", {31'd0, ifc.in_ready}, 32'd0);
      end
      if (ifc.in_valid && ifc.in_ready) idx++;
      cyc();
    end
    ifc.in_valid = 1'b0;
    chk("bp_peak", peak, EXP_PEAK);
    chk("bp_blocked", {31'd0, saw_block}, 32'd1);
    chk("bp_sent", idx, 32'd3);
    chk("bp_q_size", got_q.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size()) chk("bp_order", got_q[i], i + 1);
    got_q.delete();

    // flush a stage holding 5 (and 6 when the skid entry exists), then try to sneak 7 in
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 32'd5;
    cyc();
    ifc.in_data   = 32'd6;
    cyc();
    @(negedge CLK);
    chk("fl_pre_occ", {30'd0, ifc.occupancy}, EXP_PEAK);
    cyc();
    ifc.flush   = 1'b1;
    ifc.in_data = 32'd7;
    cyc();
    @(negedge CLK);
    chk("fl_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("fl_out_data",  ifc.out_data, 32'd0);
    chk("fl_occ",       {30'd0, ifc.occupancy}, 32'd0);
    chk("fl_in_ready",  {31'd0, ifc.in_ready}, 32'd1);
    cyc();
    ifc.flush    = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge CLK);
    chk("fl_drop_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("fl_drop_occ",   {30'd0, ifc.occupancy}, 32'd0);
    ifc.out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("fl_nothing_out", got_q.size(), 32'd0);
    got_q.delete();

    // emit during a flush cycle still reaches the consumer
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 32'd11;
    cyc();
    ifc.in_valid  = 1'b0;
    ifc.flush     = 1'b1;
    ifc.out_ready = 1'b1;
    cyc();
    ifc.flush = 1'b0;
    @(negedge CLK);
    chk("fe_occ", {30'd0, ifc.occupancy}, 32'd0);
    chk("fe_q_size", got_q.size(), 32'd1);
    if (got_q.size() > 0) chk("fe_data", got_q[0], 32'd11);
    got_q.delete();

    // reset together with flush while holding 9
    cyc();
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 32'd9;
    cyc();
    ifc.in_valid = 1'b0;
    nRST         = 1'b0;
    ifc.flush    = 1'b1;
    cyc();
    @(negedge CLK);
    chk("rf_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("rf_out_data",  ifc.out_data, 32'd0);
    chk("rf_occ",       {30'd0, ifc.occupancy}, 32'd0);
    cyc();
    nRST      = 1'b1;
    ifc.flush = 1'b0;
    cyc();
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 32'd10;
    ifc.out_ready = 1'b1;
    cyc();
    ifc.in_valid = 1'b0;
    @(negedge CLK);
    chk("rf_next_valid", {31'd0, ifc.out_valid}, 32'd1);
    chk("rf_next_data",  ifc.out_data, 32'd10);
    cyc();
    chk("rf_q_size", got_q.size(), 32'd1);
    if (got_q.size() > 0) chk("rf_q_data", got_q[0], 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
